// File: rtl/sevenseg_scan_driver.sv
// sevenseg_scan_driver: round-robin seven-segment scanner with dead-time, per-digit blanking and frame-synced double buffering.
// Define SEVSEG_DP_EN to add double-buffered decimal-point input dp_in and output dp.
module sevenseg_scan_driver #(
    parameter int NUM_DIGITS  = 2,
    parameter int REFRESH_DIV = 20,
    parameter int DEAD_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
`ifdef SEVSEG_DP_EN
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic                    dp,
`endif
    output logic [6:0]              segs,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);
    localparam int SW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [SW-1:0] LAST_SLOT = SW'(REFRESH_DIV - 1);
    localparam logic [SW-1:0] DEAD = SW'(DEAD_CYCLES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    logic [SW-1:0]           slot_cnt;
    logic [IW-1:0]           idx;
    logic                    pend;
    logic [4*NUM_DIGITS-1:0] pend_digits;
    logic [4*NUM_DIGITS-1:0] shadow_digits;
    logic [NUM_DIGITS-1:0]   pend_blank;
    logic [NUM_DIGITS-1:0]   shadow_blank;
    logic                    lit;
    logic [3:0]              nibble;

    assign frame_done = idx == LAST_IDX && slot_cnt == LAST_SLOT;
    assign nibble = shadow_digits[4*idx +: 4];
    assign lit = slot_cnt >= DEAD && !shadow_blank[idx];

    // Shadow only changes on the frame boundary so a frame never mixes old and new digits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_cnt <= '0;
            idx <= '0;
            pend <= 1'b0;
            pend_digits <= '0;
            pend_blank <= '0;
            shadow_digits <= '0;
            shadow_blank <= '1;
        end else begin
            slot_cnt <= slot_cnt == LAST_SLOT ? '0 : slot_cnt + 1'b1;
            if (slot_cnt == LAST_SLOT)
                idx <= idx == LAST_IDX ? '0 : idx + 1'b1;
            if (frame_done && pend) begin
                shadow_digits <= pend_digits;
                shadow_blank <= pend_blank;
            end
            if (load) begin
                pend_digits <= digits_in;
                pend_blank <= blank_in;
            end
            pend <= load || (pend && !frame_done);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an <= '1;
            segs <= 7'h7F;
        end else begin
            an <= lit ? ~(NUM_DIGITS'(1) << idx) : '1;
            segs <= lit ? SEG_LUT[nibble] : 7'h7F;
        end
    end

`ifdef SEVSEG_DP_EN
    logic [NUM_DIGITS-1:0] pend_dp;
    logic [NUM_DIGITS-1:0] shadow_dp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_dp <= '0;
            shadow_dp <= '0;
            dp <= 1'b1;
        end else begin
            if (load)
                pend_dp <= dp_in;
            if (frame_done && pend)
                shadow_dp <= pend_dp;
            dp <= lit ? ~shadow_dp[idx] : 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// tb_sevenseg_scan_driver: randomized self-checking bench; the reference derives each cycle's display
// from the load history and frame arithmetic alone.
module tb_sevenseg_scan_driver;
    localparam int N = 2, R = 8, D = 2, F = N * R;
    localparam logic [6:0] LUT [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           load = 1'b0;
    logic [4*N-1:0] digits_in = '0;
    logic [N-1:0]   blank_in = '0;
    logic [6:0]     segs;
    logic [N-1:0]   an;
    logic           frame_done;
`ifdef SEVSEG_DP_EN
    logic [N-1:0]   dp_in = '0;
    logic           dp;
    localparam int OW = N + 9;
    wire [OW-1:0]   obs = {an, segs, frame_done, dp};
    localparam logic [OW-1:0] DARK = {{N{1'b1}}, 7'h7F, 1'b0, 1'b1};
`else
    localparam int OW = N + 8;
    wire [OW-1:0]   obs = {an, segs, frame_done};
    localparam logic [OW-1:0] DARK = {{N{1'b1}}, 7'h7F, 1'b0};
`endif

    typedef struct packed {
        int             cyc;
        logic [4*N-1:0] dig;
        logic [N-1:0]   blk;
        logic [N-1:0]   dpv;
    } load_t;

    load_t loads[$];
    int k, checks, passed;

    sevenseg_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(R), .DEAD_CYCLES(D)) dut (
        .clk(clk),
        .reset(reset),
        .load(load),
        .digits_in(digits_in),
        .blank_in(blank_in),
`ifdef SEVSEG_DP_EN
        .dp_in(dp_in),
        .dp(dp),
`endif
        .segs(segs),
        .an(an),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Display shown for scan position s: latest load made strictly before the boundary that opened s's frame.
    function automatic logic [OW-1:0] expv(int s);
        load_t v = '{cyc: -1, dig: '0, blk: '1, dpv: '0};
        int b = (s / F) * F - 1;
        int i = (s / R) % N;
        logic on;
        foreach (loads[j]) if (loads[j].cyc < b) v = loads[j];
        on = (s % R) >= D && !v.blk[i];
        return {on ? ~(N'(1) << i) : {N{1'b1}}, on ? LUT[v.dig[4*i +: 4]] : 7'h7F, ((s + 1) % F) == F - 1
`ifdef SEVSEG_DP_EN
            , on ? ~v.dpv[i] : 1'b1
`endif
        };
    endfunction

    task automatic tick(input logic ld, input logic [4*N-1:0] dg, input logic [N-1:0] bk, input logic [N-1:0] dv);
        load = ld;
        digits_in = dg;
        blank_in = bk;
`ifdef SEVSEG_DP_EN
        dp_in = dv;
`endif
        if (ld) loads.push_back('{k, dg, bk, dv});
        @(posedge clk);
        #1;
        k++;
        load = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if (obs !== DARK) $display("FAIL reset_state got=%h want=%h", obs, DARK);
        else passed++;
        reset = 1'b0;
        k = 0;
        loads.delete();
        repeat (3 * F) begin
            tick(1'b0, '0, '0, '0);
            checks++;
            if (obs !== expv(k - 1)) $display("FAIL dark_no_load k=%0d got=%h want=%h", k, obs, expv(k - 1));
            else passed++;
        end
    endtask

    task automatic test_basic;
        tick(1'b1, 8'h3A, 2'b00, 2'b00);
        repeat (3 * F) begin
            tick(1'b0, '0, '0, '0);
            checks++;
            if (obs !== expv(k - 1)) $display("FAIL basic_3A k=%0d got=%h want=%h", k, obs, expv(k - 1));
            else passed++;
        end
    endtask

    task automatic test_sweep;
        for (int d = 0; d < 16; d++) begin
            tick(1'b1, {4'($urandom), 4'(d)}, 2'b00, 2'($urandom));
            repeat (F - 1) begin
                tick(1'b0, '0, '0, '0);
                checks++;
                if (obs !== expv(k - 1)) $display("FAIL sweep d=%0d k=%0d got=%h want=%h", d, k, obs, expv(k - 1));
                else passed++;
            end
        end
        repeat (2 * F) begin
            tick(1'b0, '0, '0, '0);
            checks++;
            if (obs !== expv(k - 1)) $display("FAIL sweep_tail k=%0d got=%h want=%h", k, obs, expv(k - 1));
            else passed++;
        end
    endtask

    task automatic test_two_loads;
        int ones = 0;
        int bstart;
        while (k % F != 1) begin
            tick(1'b0, '0, '0, '0);
            checks++;
            if (obs !== expv(k - 1)) $display("FAIL two_loads_align k=%0d got=%h want=%h", k, obs, expv(k - 1));
            else passed++;
        end
        tick(1'b1, 8'h11, 2'b00, 2'b11);
        repeat (3) tick(1'b0, '0, '0, '0);
        bstart = ((k - 1) / F + 1) * F;
        tick(1'b1, 8'h22, 2'b00, 2'b00);
        repeat (3 * F) begin
            tick(1'b0, '0, '0, '0);
            if (k - 1 >= bstart && segs == 7'h4F) ones++;
            checks++;
            if (obs !== expv(k - 1)) $display("FAIL two_loads k=%0d got=%h want=%h", k, obs, expv(k - 1));
            else passed++;
        end
        checks++;
        if (ones !== 0) $display("FAIL two_loads_never_1 got=%0d cycles showing 1 want=0", ones);
        else passed++;
    endtask

    task automatic test_boundary_load;
        while (k % F != 5) tick(1'b0, '0, '0, '0);
        tick(1'b1, 8'h5C, 2'b00, 2'b10);
        while (k % F != F - 1) tick(1'b0, '0, '0, '0);
        checks++;
        if (frame_done !== 1'b1) $display("FAIL boundary_frame_done got=%b want=1", frame_done);
        else passed++;
        tick(1'b1, 8'hE7, 2'b00, 2'b01);
        repeat (3 * F) begin
            tick(1'b0, '0, '0, '0);
            checks++;
            if (obs !== expv(k - 1)) $display("FAIL boundary_load k=%0d got=%h want=%h", k, obs, expv(k - 1));
            else passed++;
        end
    endtask

    task automatic test_reset_mid;
        int guard = 0;
        while (an === {N{1'b1}} && guard < 2 * F) begin
            tick(1'b0, '0, '0, '0);
            guard++;
        end
        checks++;
        if (an === {N{1'b1}}) $display("FAIL reset_mid_lit got=%b want=a lit digit", an);
        else passed++;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (obs !== DARK) $display("FAIL reset_mid_async got=%h want=%h", obs, DARK);
        else passed++;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        k = 0;
        loads.delete();
        repeat (2 * F) begin
            tick(1'b0, '0, '0, '0);
            checks++;
            if (obs !== expv(k - 1)) $display("FAIL reset_mid_after k=%0d got=%h want=%h", k, obs, expv(k - 1));
            else passed++;
        end
    endtask

`ifdef SEVSEG_DP_EN
    task automatic test_dp;
        tick(1'b1, 8'($urandom), 2'b10, 2'b01);
        repeat (3 * F) begin
            tick(1'b0, '0, '0, '0);
            checks++;
            if (obs !== expv(k - 1)) $display("FAIL dp k=%0d got=%h want=%h", k, obs, expv(k - 1));
            else passed++;
        end
    endtask
`endif

    task automatic test_random;
        repeat (40 * F) begin
            if ($urandom_range(0, 9) == 0) tick(1'b1, 8'($urandom), 2'($urandom), 2'($urandom));
            else tick(1'b0, 8'($urandom), 2'($urandom), 2'($urandom));
            checks++;
            if (obs !== expv(k - 1)) $display("FAIL random k=%0d got=%h want=%h", k, obs, expv(k - 1));
            else passed++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        passed = 0;
        k = 0;
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        test_basic;
        test_sweep;
        test_two_loads;
        test_boundary_load;
        test_reset_mid;
`ifdef SEVSEG_DP_EN
        test_dp;
`endif
        test_random;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
